// File: rtl/cs_measure_ctrl.sv
// rtl/cs_measure_ctrl.sv - compressed-sensing row-sum measurement controller
// Walks an index ROM, fetches indexed samples and emits one unsigned sum per measurement row.
module cs_measure_ctrl #(
    parameter int M_ROWS = 48,
    parameter int K_NZ   = 8,
    parameter int N_COLS = 96,
    parameter int DW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [9:0]    rom_addr,
    input  logic [7:0]    rom_q,
    output logic [6:0]    smp_addr,
    input  logic [DW-1:0] smp_data,
    output logic          y_valid,
    output logic [5:0]    y_idx,
    output logic [DW+2:0] y_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int KW = (K_NZ > 1) ? $clog2(K_NZ) : 1;
    localparam logic [KW-1:0] LAST_K    = KW'(K_NZ - 1);
    localparam logic [5:0]    LAST_ROW  = 6'(M_ROWS - 1);
    localparam logic [9:0]    LAST_ADDR = 10'(M_ROWS * K_NZ - 1);
    localparam logic [7:0]    COL_LIMIT = 8'(N_COLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state_q;
    logic [9:0]      rom_addr_q;
    logic [KW-1:0]   k_q;
    logic [5:0]      row_q;

    // Stage 1: tags travelling alongside the ROM read, rom_q valid in this stage.
    logic            s1_vld_q;
    logic [KW-1:0]   s1_k_q;
    logic [5:0]      s1_row_q;

    // Stage 2: tags travelling alongside the sample read, smp_data valid in this stage.
    logic            s2_vld_q;
    logic [KW-1:0]   s2_k_q;
    logic [5:0]      s2_row_q;
    logic            s2_bad_q;

    logic [DW+2:0]   acc_q;
    logic [DW+2:0]   acc_d;
    logic [DW+2:0]   addend;
    logic            bad_idx;

    logic            y_valid_q;
    logic [5:0]      y_idx_q;
    logic [DW+2:0]   y_data_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    assign bad_idx  = (rom_q >= COL_LIMIT);
    assign smp_addr = rom_q[6:0];

    // An out-of-range column contributes nothing; element 0 restarts the row sum.
    always_comb begin
        addend = '0;
        acc_d  = '0;
        addend = s2_bad_q ? '0 : {3'b000, smp_data};
        acc_d  = (s2_k_q == '0) ? addend : (acc_q + addend);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            k_q        <= '0;
            row_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_k_q     <= '0;
            s1_row_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_k_q     <= '0;
            s2_row_q   <= '0;
            s2_bad_q   <= 1'b0;
            acc_q      <= '0;
            y_valid_q  <= 1'b0;
            y_idx_q    <= '0;
            y_data_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
            s1_vld_q  <= 1'b0;

            s2_vld_q  <= s1_vld_q;
            s2_k_q    <= s1_k_q;
            s2_row_q  <= s1_row_q;
            s2_bad_q  <= s1_vld_q && bad_idx;
            if (s1_vld_q && bad_idx) begin
                err_q <= 1'b1;
            end

            if (s2_vld_q) begin
                acc_q <= acc_d;
                if (s2_k_q == LAST_K) begin
                    y_valid_q <= 1'b1;
                    y_data_q  <= acc_d;
                    y_idx_q   <= s2_row_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        rom_addr_q <= '0;
                        k_q        <= '0;
                        row_q      <= '0;
                        err_q      <= 1'b0;
                    end
                end
                RUN: begin
                    s1_vld_q <= 1'b1;
                    s1_k_q   <= k_q;
                    s1_row_q <= row_q;
                    if (rom_addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                    end else begin
                        rom_addr_q <= rom_addr_q + 10'd1;
                    end
                    if (k_q == LAST_K) begin
                        k_q   <= '0;
                        row_q <= row_q + 6'd1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DRAIN: begin
                    if (y_valid_q && (y_idx_q == LAST_ROW)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign y_valid  = y_valid_q;
    assign y_idx    = y_idx_q;
    assign y_data   = y_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cs_measure_ctrl.sv
// tb/tb_cs_measure_ctrl.sv - scoreboard bench for cs_measure_ctrl
module tb_cs_measure_ctrl;

    localparam int M = 48;
    localparam int K = 8;
    localparam int N = 96;
    localparam int DW = 12;
    localparam int LAST_Y = 387;
    localparam int DONE_CYC = 388;

    typedef struct {
        int idx;
        int data;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    rom_addr;
    logic [7:0]    rom_q;
    logic [6:0]    smp_addr;
    logic [DW-1:0] smp_data;
    logic          y_valid;
    logic [5:0]    y_idx;
    logic [DW+2:0] y_data;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0]    rom_mem [0:M*K-1];
    logic [DW-1:0] smp_mem [0:127];
    exp_t          sb [$];
    int            got_y [0:M-1];
    int            checks = 0;
    int            errors = 0;
    int            tcount = 0;
    int            frame_base = 0;
    int            exp0 = 0;

    cs_measure_ctrl #(.M_ROWS(M), .K_NZ(K), .N_COLS(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .smp_addr(smp_addr), .smp_data(smp_data),
        .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcount   <= tcount + 1;
        rom_q    <= (rom_addr < 10'(M*K)) ? rom_mem[rom_addr] : 8'd0;
        smp_data <= smp_mem[smp_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every y_valid pops the next expected row.
    always @(negedge clk) begin
        if (y_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_y_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y_idx", 32'(y_idx), 32'(e.idx));
                check("y_data", 32'(y_data), 32'(e.data));
                check("y_cycle", 32'(tcount - frame_base), 32'(e.cyc));
                got_y[e.idx] = int'(y_data);
            end
        end
    end

    task automatic load_expected();
        exp_t e;
        sb.delete();
        for (int r = 0; r < M; r++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < K; k++) begin
                int ix;
                ix = int'(rom_mem[r*K+k]);
                if (ix < N) sum += int'(smp_mem[ix]);
            end
            e.idx  = r;
            e.data = sum;
            e.cyc  = 11 + 8*r;
            sb.push_back(e);
            if (r == 0) exp0 = sum;
        end
    endtask

    task automatic run_frame(input int p1, input int p2, input int rstc, input int err_from);
        int left;
        load_expected();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        frame_base = tcount - 1;
        for (int c = 1; c <= 400; c++) begin
            logic busy_exp;
            busy_exp = (rstc != 0) ? (c <= rstc) : (c <= DONE_CYC);
            check("busy", 32'(busy), 32'(busy_exp));
            check("done", 32'(done), 32'((rstc == 0) && (c == DONE_CYC)));
            check("err", 32'(err), 32'((err_from != 0) && (c >= err_from)));
            if (rstc != 0 && c > rstc) begin
                check("rom_addr_after_rst", 32'(rom_addr), 32'd0);
            end else if (c <= M*K) begin
                check("rom_addr", 32'(rom_addr), 32'(c - 1));
            end
            if (rstc != 0 && c == rstc + 1) begin
                check("y_valid_after_rst", 32'(y_valid), 32'd0);
                check("y_data_after_rst", 32'(y_data), 32'd0);
                check("y_idx_after_rst", 32'(y_idx), 32'd0);
            end
            if (rstc == 0 && c == 12) begin
                check("y_data_hold", 32'(y_data), 32'(exp0));
                check("y_idx_hold", 32'(y_idx), 32'd0);
            end
            start = (c == p1) || (c == p2);
            rst   = (c == rstc);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        left  = (rstc != 0) ? (M - (rstc - 3) / 8) : 0;
        check("rows_left", 32'(sb.size()), 32'(left));
        sb.delete();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int r = 0; r < M; r++)
            for (int k = 0; k < K; k++)
                rom_mem[r*K+k] = 8'((r + 12*k) % N);
        rom_mem[7]   = 8'd54;
        rom_mem[380] = 8'd17;
        for (int i = 0; i < 128; i++) smp_mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_y_data", 32'(y_data), 32'd0);
        check("rst_y_idx", 32'(y_idx), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 128; i++) smp_mem[i] = DW'(1);
        run_frame(0, 0, 0, 0);

        for (int i = 0; i < 128; i++) smp_mem[i] = DW'(i);
        run_frame(0, 0, 0, 0);
        check("ramp_y0", 32'(got_y[0]), 32'd306);
        check("ramp_y47", 32'(got_y[M-1]), 32'd346);

        for (int i = 0; i < 128; i++) smp_mem[i] = DW'(4095);
        run_frame(0, 0, 0, 0);
        check("max_y0", 32'(got_y[0]), 32'd32760);

        for (int i = 0; i < 128; i++) smp_mem[i] = DW'(i);
        run_frame(0, 0, 100, 0);
        run_frame(0, 0, 0, 0);
        check("post_rst_y47", 32'(got_y[M-1]), 32'd346);

        for (int i = 0; i < 128; i++) smp_mem[i] = DW'(1);
        run_frame(50, DONE_CYC, 0, 0);

        for (int i = 0; i < 128; i++) smp_mem[i] = DW'(i);
        smp_mem[100] = DW'(777);
        rom_mem[5]   = 8'd100;
        run_frame(0, 0, 0, 8);
        check("bad_idx_y0", 32'(got_y[0]), 32'd246);
        rom_mem[5]   = 8'd60;
        run_frame(0, 0, 0, 0);
        check("restored_y0", 32'(got_y[0]), 32'd306);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
